canal_lock_controller: RTL and testbench

- Sequencer for the canal-lock datapath: outer water, inner water and the lock chamber.
- Arbitrates boat requests from the outer and inner sides and equalizes chamber water to the requesting side.
- Opens, holds and closes gates, then equalizes to the far side and releases the boat.
- Runs on the divided slow clock from the top level; drives gate LEDs and the lockWater value shown on the HEX displays.

---
 rtl/canal_lock_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_canal_lock_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/canal_lock_controller.sv
// canal_lock_controller
// Sequences a boat through the lock chamber: arbitrates outer/inner requests,
// equalizes the chamber to the boat's side, cycles the gates, equalizes to the
// far side and releases the boat. All outputs are registered.
// Optional boat-entry timeout in WAIT_IN: define LOCK_TIMEOUT_EN.
module canal_lock_controller #(
  parameter logic [7:0] OUTER_LEVEL    = 8'd20,
  parameter logic [7:0] INNER_LEVEL    = 8'd80,
  parameter logic [7:0] STEP           = 8'd4,
  parameter logic [3:0] GATE_CYCLES    = 4'd3,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_outer,
  input  logic       req_inner,
  input  logic       boat_in,
  input  logic       boat_out,
  output logic       outer_gate_open,
  output logic       inner_gate_open,
  output logic [7:0] lock_water,
  output logic       filling,
  output logic       draining,
  output logic       grant_outer,
  output logic       grant_inner,
  output logic       busy,
  output logic [3:0] state,
  output logic       timeout
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    EQ_IN     = 4'd1,
    OPEN_IN   = 4'd2,
    WAIT_IN   = 4'd3,
    CLOSE_IN  = 4'd4,
    EQ_OUT    = 4'd5,
    OPEN_OUT  = 4'd6,
    WAIT_OUT  = 4'd7,
    CLOSE_OUT = 4'd8
  } state_t;

  state_t     cur_state;
  logic       src_inner;   // side the current boat came from (1 = inner)
  logic       last_inner;  // side served last (1 = inner); loser of the next tie
  logic [3:0] gate_cnt;
  logic [7:0] src_level;
  logic [7:0] dst_level;
  logic       gate_done;

`ifdef LOCK_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       aborted;     // remembers that CLOSE_IN was entered by a timeout
`endif

  // Move one STEP toward the target, landing exactly on it when closer than
  // one STEP so the level never overshoots or wraps.
  function automatic logic [7:0] sat_step(input logic [7:0] cur, input logic [7:0] tgt);
    if (tgt > cur)
      return ((tgt - cur) < STEP) ? tgt : cur + STEP;
    else if (tgt < cur)
      return ((cur - tgt) < STEP) ? tgt : cur - STEP;
    else
      return cur;
  endfunction

  assign src_level = src_inner ? INNER_LEVEL : OUTER_LEVEL;
  assign dst_level = src_inner ? OUTER_LEVEL : INNER_LEVEL;
  assign gate_done = (gate_cnt >= (GATE_CYCLES - 4'd1));
  assign state     = cur_state;

  // Lock sequencer: state, water level, gates and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state       <= IDLE;
      lock_water      <= OUTER_LEVEL;
      outer_gate_open <= 1'b0;
      inner_gate_open <= 1'b0;
      filling         <= 1'b0;
      draining        <= 1'b0;
      grant_outer     <= 1'b0;
      grant_inner     <= 1'b0;
      busy            <= 1'b0;
      src_inner       <= 1'b0;
      last_inner      <= 1'b1;
      gate_cnt        <= 4'd0;
`ifdef LOCK_TIMEOUT_EN
      wait_cnt        <= 8'd0;
      aborted         <= 1'b0;
      timeout         <= 1'b0;
`endif
    end else begin
      grant_outer <= 1'b0;
      grant_inner <= 1'b0;
      filling     <= 1'b0;
      draining    <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
      timeout     <= 1'b0;
`endif
      case (cur_state)
        IDLE: begin
          if (req_outer || req_inner) begin
            // On a tie the side not served last wins.
            if (req_outer && (!req_inner || last_inner)) begin
              src_inner   <= 1'b0;
              grant_outer <= 1'b1;
            end else begin
              src_inner   <= 1'b1;
              grant_inner <= 1'b1;
            end
            cur_state <= EQ_IN;
            busy      <= 1'b1;
          end
        end
        EQ_IN: begin
          if (lock_water == src_level) begin
            cur_state <= OPEN_IN;
            gate_cnt  <= 4'd0;
          end else begin
            lock_water <= sat_step(lock_water, src_level);
            filling    <= (src_level > lock_water);
            draining   <= (src_level < lock_water);
          end
        end
        OPEN_IN: begin
          if (gate_done) begin
            cur_state       <= WAIT_IN;
            outer_gate_open <= !src_inner;
            inner_gate_open <= src_inner;
`ifdef LOCK_TIMEOUT_EN
            wait_cnt        <= 8'd0;
`endif
          end else begin
            gate_cnt <= gate_cnt + 4'd1;
          end
        end
        WAIT_IN: begin
          if (boat_in) begin
            cur_state       <= CLOSE_IN;
            outer_gate_open <= 1'b0;
            inner_gate_open <= 1'b0;
            gate_cnt        <= 4'd0;
          end
`ifdef LOCK_TIMEOUT_EN
          else if (wait_cnt >= (TIMEOUT_CYCLES - 8'd1)) begin
            cur_state       <= CLOSE_IN;
            outer_gate_open <= 1'b0;
            inner_gate_open <= 1'b0;
            gate_cnt        <= 4'd0;
            timeout         <= 1'b1;
            aborted         <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        CLOSE_IN: begin
          if (gate_done) begin
`ifdef LOCK_TIMEOUT_EN
            if (aborted) begin
              // Abandoned entry: chamber stays at the source level.
              cur_state  <= IDLE;
              busy       <= 1'b0;
              last_inner <= src_inner;
              aborted    <= 1'b0;
            end else begin
              cur_state <= EQ_OUT;
            end
`else
            cur_state <= EQ_OUT;
`endif
          end else begin
            gate_cnt <= gate_cnt + 4'd1;
          end
        end
        EQ_OUT: begin
          if (lock_water == dst_level) begin
            cur_state <= OPEN_OUT;
            gate_cnt  <= 4'd0;
          end else begin
            lock_water <= sat_step(lock_water, dst_level);
            filling    <= (dst_level > lock_water);
            draining   <= (dst_level < lock_water);
          end
        end
        OPEN_OUT: begin
          if (gate_done) begin
            cur_state       <= WAIT_OUT;
            outer_gate_open <= src_inner;
            inner_gate_open <= !src_inner;
          end else begin
            gate_cnt <= gate_cnt + 4'd1;
          end
        end
        WAIT_OUT: begin
          if (boat_out) begin
            cur_state       <= CLOSE_OUT;
            outer_gate_open <= 1'b0;
            inner_gate_open <= 1'b0;
            gate_cnt        <= 4'd0;
          end
        end
        CLOSE_OUT: begin
          if (gate_done) begin
            cur_state  <= IDLE;
            busy       <= 1'b0;
            last_inner <= src_inner;
          end else begin
            gate_cnt <= gate_cnt + 4'd1;
          end
        end
        default: begin
          cur_state       <= IDLE;
          outer_gate_open <= 1'b0;
          inner_gate_open <= 1'b0;
          busy            <= 1'b0;
          gate_cnt        <= 4'd0;
        end
      endcase
    end
  end

`ifndef LOCK_TIMEOUT_EN
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_canal_lock_controller.sv
// Bench for canal_lock_controller. Two instances (STEP=4 and STEP=7) are driven
// with randomized transactions. For each transaction the bench derives the
// expected per-cycle trace of every output from the lock's rules (arbitration,
// stepwise equalization, gate timing, boat waits) and compares cycle by cycle.
module tb_canal_lock_controller;
  localparam int ND      = 2;
  localparam int OUTER_I = 20;
  localparam int INNER_I = 80;
  localparam int G       = 3;
  localparam int TMO     = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset           [ND];
  logic       req_outer       [ND];
  logic       req_inner       [ND];
  logic       boat_in         [ND];
  logic       boat_out        [ND];
  logic       outer_gate_open [ND];
  logic       inner_gate_open [ND];
  logic [7:0] lock_water      [ND];
  logic       filling         [ND];
  logic       draining        [ND];
  logic       grant_outer     [ND];
  logic       grant_inner     [ND];
  logic       busy            [ND];
  logic [3:0] state           [ND];
  logic       timeout         [ND];

  for (genvar d = 0; d < ND; d++) begin : g_dut
    canal_lock_controller #(.STEP((d == 0) ? 8'd4 : 8'd7)) dut (
      .clk             (clk),
      .reset           (reset[d]),
      .req_outer       (req_outer[d]),
      .req_inner       (req_inner[d]),
      .boat_in         (boat_in[d]),
      .boat_out        (boat_out[d]),
      .outer_gate_open (outer_gate_open[d]),
      .inner_gate_open (inner_gate_open[d]),
      .lock_water      (lock_water[d]),
      .filling         (filling[d]),
      .draining        (draining[d]),
      .grant_outer     (grant_outer[d]),
      .grant_inner     (grant_inner[d]),
      .busy            (busy[d]),
      .state           (state[d]),
      .timeout         (timeout[d])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: chamber level and last-served side (1 = inner) per DUT.
  int lw_m   [ND];
  bit last_m [ND];

  // Expected visible-cycle words and the input drive applied during each.
  logic [19:0] vq[$];
  logic [4:0]  dq[$];

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {state, outer_gate, inner_gate, lock_water, filling, draining, grant_o, grant_i, busy, timeout}
  function automatic logic [19:0] W(input int st, input bit og, input bit ig, input int lw,
                                    input bit f, input bit dr, input bit go, input bit gi,
                                    input bit b, input bit to);
    logic [3:0] s4;
    logic [7:0] l8;
    s4 = st[3:0];
    l8 = lw[7:0];
    return {s4, og, ig, l8, f, dr, go, gi, b, to};
  endfunction

  function automatic logic [19:0] obs(input int d);
    return {state[d], outer_gate_open[d], inner_gate_open[d], lock_water[d], filling[d],
            draining[d], grant_outer[d], grant_inner[d], busy[d], timeout[d]};
  endfunction

  function automatic int toward(input int cur, input int tgt, input int st);
    if (tgt > cur) return (tgt - cur < st) ? tgt : cur + st;
    if (tgt < cur) return (cur - tgt < st) ? tgt : cur - st;
    return cur;
  endfunction

  // Random requests always; boat pulses only where allowed.
  function automatic logic [4:0] nz(input bit bin_ok, input bit bout_ok);
    logic [4:0] v;
    v[4] = 1'b0;
    v[3] = 1'($urandom_range(0, 1));
    v[2] = 1'($urandom_range(0, 1));
    v[1] = bin_ok && ($urandom_range(0, 3) == 0);
    v[0] = bout_ok && ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  task automatic apply(input int d, input logic [4:0] v);
    reset[d]     = v[4];
    req_outer[d] = v[3];
    req_inner[d] = v[2];
    boat_in[d]   = v[1];
    boat_out[d]  = v[0];
  endtask

  task automatic step(input logic [19:0] w, input logic [4:0] drv);
    vq.push_back(w);
    dq.push_back(drv);
  endtask

  task automatic build_idle(input int d);
    vq.delete();
    dq.delete();
    step(W(0, 0, 0, lw_m[d], 0, 0, 0, 0, 0, 0), {3'b000, nz(1, 1) & 5'b00011});
    vq.push_back(W(0, 0, 0, lw_m[d], 0, 0, 0, 0, 0, 0));
  endtask

  task automatic build_txn(input int d, input bit ro, input bit ri, input int kin,
                           input int kout, input bit do_reset);
    int L, st, ts, td, nl, nwait;
    bit src, tmo;
    logic [4:0] n;
    L   = lw_m[d];
    st  = (d == 0) ? 4 : 7;
    src = (ro && ri) ? !last_m[d] : ri;
    ts  = src ? INNER_I : OUTER_I;
    td  = src ? OUTER_I : INNER_I;
    vq.delete();
    dq.delete();
    n = nz(1, 1);
    step(W(0, 0, 0, L, 0, 0, 0, 0, 0, 0), {1'b0, ro, ri, n[1:0]});
    step(W(1, 0, 0, L, 0, 0, !src, src, 1, 0), nz(1, 1));
    while (L != ts) begin
      nl = toward(L, ts, st);
      step(W(1, 0, 0, nl, nl > L, nl < L, 0, 0, 1, 0), nz(1, 1));
      L = nl;
    end
    for (int g = 0; g < G; g++) step(W(2, 0, 0, L, 0, 0, 0, 0, 1, 0), nz(1, 1));
    tmo = 1'b0;
`ifdef LOCK_TIMEOUT_EN
    tmo = (kin > TMO);
`endif
    nwait = tmo ? TMO : kin;
    for (int j = 1; j <= nwait; j++) begin
      n = nz(0, 1);
      n[1] = (j == kin);
      step(W(3, !src, src, L, 0, 0, 0, 0, 1, 0), n);
    end
    for (int g = 0; g < G; g++) step(W(4, 0, 0, L, 0, 0, 0, 0, 1, tmo && (g == 0)), nz(1, 1));
    if (tmo) begin
      vq.push_back(W(0, 0, 0, L, 0, 0, 0, 0, 0, 0));
      last_m[d] = src;
      lw_m[d]   = L;
      return;
    end
    step(W(5, 0, 0, L, 0, 0, 0, 0, 1, 0), nz(1, 1));
    while (L != td) begin
      nl = toward(L, td, st);
      step(W(5, 0, 0, nl, nl > L, nl < L, 0, 0, 1, 0), nz(1, 1));
      L = nl;
    end
    for (int g = 0; g < G; g++) step(W(6, 0, 0, L, 0, 0, 0, 0, 1, 0), nz(1, 1));
    if (do_reset) begin
      step(W(7, src, !src, L, 0, 0, 0, 0, 1, 0), 5'b10000);
      vq.push_back(W(0, 0, 0, OUTER_I, 0, 0, 0, 0, 0, 0));
      lw_m[d]   = OUTER_I;
      last_m[d] = 1'b1;
      return;
    end
    for (int j = 1; j <= kout; j++) begin
      n = nz(1, 0);
      n[0] = (j == kout);
      step(W(7, src, !src, L, 0, 0, 0, 0, 1, 0), n);
    end
    for (int g = 0; g < G; g++) step(W(8, 0, 0, L, 0, 0, 0, 0, 1, 0), nz(1, 1));
    vq.push_back(W(0, 0, 0, L, 0, 0, 0, 0, 0, 0));
    last_m[d] = src;
    lw_m[d]   = L;
  endtask

  task automatic run_plan(input int d, input string name);
    for (int i = 0; i < dq.size(); i++) begin
      apply(d, dq[i]);
      @(posedge clk);
      #1;
      check($sformatf("%s_d%0d_c%0d", name, d, i), obs(d), vq[i+1]);
    end
    apply(d, 5'b00000);
  endtask

  initial begin
    int d, k, kin, kout;
    for (int i = 0; i < ND; i++) apply(i, 5'b10000);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      apply(i, 5'b00000);
      lw_m[i]   = OUTER_I;
      last_m[i] = 1'b1;
      check($sformatf("reset_d%0d", i), obs(i), W(0, 0, 0, OUTER_I, 0, 0, 0, 0, 0, 0));
    end

    // Directed: single outer request, full transit on STEP=4.
    build_txn(0, 1, 0, 2, 3, 0);  run_plan(0, "outer_first");
    // Directed: tie after reset goes outer, tie again goes inner (STEP=7 fill and drain).
    build_txn(1, 1, 1, 1, 1, 0);  run_plan(1, "tie_first");
    build_txn(1, 1, 1, 3, 2, 0);  run_plan(1, "tie_second");
    // Directed: inner request when chamber already at inner level.
    build_txn(0, 0, 1, 4, 2, 0);  run_plan(0, "inner_ready");
    // Long boat-entry wait: times out with the feature, otherwise gate stays open.
    build_txn(0, 1, 0, 210, 1, 0); run_plan(0, "long_wait");

    for (int t = 0; t < 16; t++) begin
      d = $urandom_range(0, ND - 1);
      if ($urandom_range(0, 5) == 0) begin
        build_idle(d);
        run_plan(d, "idle");
      end
      k    = $urandom_range(1, 3);
      kin  = $urandom_range(1, 12);
      kout = $urandom_range(1, 12);
      if ($urandom_range(0, 7) == 0) kin = TMO + $urandom_range(0, 1);
      build_txn(d, k[0], k[1], kin, kout, 0);
      run_plan(d, "rand");
    end

    // Reset while the far gate is open.
    build_txn(0, 1, 0, 2, 2, 1);  run_plan(0, "reset_wait_out");
    // Tie right after reset must go to outer again.
    build_txn(0, 1, 1, 1, 1, 0);  run_plan(0, "tie_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
